// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state/owner encodings and counter sizing for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // The read counter runs 0..rd_lat, so it needs room for rd_lat itself.
  function automatic int cnt_width(input int rd_lat);
    return (rd_lat < 1) ? 1 : $clog2(rd_lat + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D port arbiter for one shared single-port RAM
// Define MEM_ARBITER_RR_EN for round-robin arbitration (default: data port has fixed priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_st,
  output logic          mem_oe,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = cnt_width(RD_LAT);

  state_t        state, state_n;
  owner_t        owner, owner_n, grant;
  logic          we_q, we_n;
  logic [CW-1:0] cnt, cnt_n;

  logic          mem_st_n, mem_oe_n, i_ack_n, d_ack_n, busy_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, i_rdata_n, d_rdata_n;

`ifdef MEM_ARBITER_RR_EN
  owner_t last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWN_D;
    end else if (state == ST_IDLE && (i_req || d_req)) begin
      last_grant <= grant;
    end
  end
`endif

  always_comb begin
    grant = d_req ? OWN_D : OWN_I;
`ifdef MEM_ARBITER_RR_EN
    if (d_req && i_req) begin
      grant = (last_grant == OWN_D) ? OWN_I : OWN_D;
    end
`endif
  end

  // mem_addr/mem_wdata double as the latched request; RD_LAT reads spend one
  // extra ACCESS cycle with oe low while the RAM's data arrives.
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    we_n        = we_q;
    cnt_n       = cnt;
    mem_st_n    = 1'b0;
    mem_oe_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    i_ack_n     = 1'b0;
    d_ack_n     = 1'b0;
    i_rdata_n   = i_rdata;
    d_rdata_n   = d_rdata;

    unique case (state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_n    = ST_ACCESS;
          owner_n    = grant;
          cnt_n      = '0;
          we_n       = (grant == OWN_D) && d_we;
          mem_addr_n = (grant == OWN_D) ? d_addr : i_addr;
          if (we_n) begin
            mem_st_n    = 1'b1;
            mem_wdata_n = d_wdata;
          end else begin
            mem_oe_n = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_n = ST_RESP;
          i_ack_n = (owner == OWN_I);
          d_ack_n = (owner == OWN_D);
        end else if (cnt == CW'(RD_LAT)) begin
          state_n = ST_RESP;
          i_ack_n = (owner == OWN_I);
          d_ack_n = (owner == OWN_D);
          if (owner == OWN_I) begin
            i_rdata_n = mem_rdata;
          end else begin
            d_rdata_n = mem_rdata;
          end
        end else begin
          cnt_n    = cnt + 1'b1;
          mem_oe_n = (cnt < CW'(RD_LAT - 1));
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_I;
      we_q      <= 1'b0;
      cnt       <= '0;
      mem_st    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      we_q      <= we_n;
      cnt       <= cnt_n;
      mem_st    <= mem_st_n;
      mem_oe    <= mem_oe_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      i_ack     <= i_ack_n;
      d_ack     <= d_ack_n;
      i_rdata   <= i_rdata_n;
      d_rdata   <= d_rdata_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with RD_LAT=1 and RD_LAT=3 instances
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int NU = 2;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req     [NU];
  logic [15:0] i_addr    [NU];
  logic        i_ack     [NU];
  logic [15:0] i_rdata   [NU];
  logic        d_req     [NU];
  logic        d_we      [NU];
  logic [15:0] d_addr    [NU];
  logic [15:0] d_wdata   [NU];
  logic        d_ack     [NU];
  logic [15:0] d_rdata   [NU];
  logic        mem_st    [NU];
  logic        mem_oe    [NU];
  logic [15:0] mem_addr  [NU];
  logic [15:0] mem_wdata [NU];
  logic [15:0] mem_rdata [NU];
  logic        busy      [NU];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          u;
    bit          port_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        tbl    [8];
  logic [15:0] shadow [NU][16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [15:0] ram  [256];
    logic [15:0] pipe [LAT];

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .mem_st(mem_st[g]), .mem_oe(mem_oe[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // RAM returns the word LAT cycles after an oe cycle, zero otherwise.
    always @(posedge clk) begin
      if (mem_st[g]) ram[mem_addr[g][7:0]] <= mem_wdata[g];
      pipe[0] <= mem_oe[g] ? ram[mem_addr[g][7:0]] : 16'h0000;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int u = 0; u < NU; u++) begin
        n_chk++;
        if ((i_ack[u] && d_ack[u]) || (mem_st[u] && mem_oe[u])) begin
          n_fail++;
          $display("FAIL exclusive u%0d: i_ack=%b d_ack=%b mem_st=%b mem_oe=%b",
                   u, i_ack[u], d_ack[u], mem_st[u], mem_oe[u]);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_idle(input int u, input string nm);
    chk({nm, " mem_st"},    32'(mem_st[u]),    0);
    chk({nm, " mem_oe"},    32'(mem_oe[u]),    0);
    chk({nm, " mem_addr"},  32'(mem_addr[u]),  0);
    chk({nm, " mem_wdata"}, 32'(mem_wdata[u]), 0);
    chk({nm, " i_ack"},     32'(i_ack[u]),     0);
    chk({nm, " d_ack"},     32'(d_ack[u]),     0);
    chk({nm, " i_rdata"},   32'(i_rdata[u]),   0);
    chk({nm, " d_rdata"},   32'(d_rdata[u]),   0);
    chk({nm, " busy"},      32'(busy[u]),      0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int u = 0; u < NU; u++) begin
      i_req[u] = 1'b0;
      d_req[u] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated transaction; ack must land (we ? 2 : RD_LAT+2) cycles after the req cycle.
  task automatic txn(input int u, input bit port_d, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_rd, input string nm);
    int          exp_lat, n_st, n_oe, n_bad, got;
    logic [15:0] other;
    exp_lat = we ? 2 : lat_of(u) + 2;
    n_st = 0; n_oe = 0; n_bad = 0; got = 0;
    @(negedge clk);
    other = port_d ? i_rdata[u] : d_rdata[u];
    if (port_d) begin
      d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = addr; d_wdata[u] = wdata;
    end else begin
      i_req[u] = 1'b1; i_addr[u] = addr;
    end
    for (int c = 1; c <= 20 && got == 0; c++) begin
      @(negedge clk);
      if (mem_st[u]) n_st++;
      if (mem_oe[u]) n_oe++;
      if ((mem_st[u] || mem_oe[u]) && mem_addr[u] !== addr) n_bad++;
      if (mem_st[u] && mem_wdata[u] !== wdata) n_bad++;
      if ((port_d ? d_ack[u] : i_ack[u]) === 1'b1) got = c;
    end
    d_req[u] = 1'b0;
    i_req[u] = 1'b0;
    chk({nm, " latency"},   32'(got), 32'(exp_lat));
    chk({nm, " st cycles"}, 32'(n_st), we ? 1 : 0);
    chk({nm, " oe cycles"}, 32'(n_oe), we ? 0 : 32'(lat_of(u)));
    chk({nm, " addr/data"}, 32'(n_bad), 0);
    if (!we) chk({nm, " rdata"}, 32'(port_d ? d_rdata[u] : i_rdata[u]), 32'(exp_rd));
    chk({nm, " other rdata"}, 32'(port_d ? i_rdata[u] : d_rdata[u]), 32'(other));
    @(negedge clk);
    chk({nm, " ack width"}, 32'(port_d ? d_ack[u] : i_ack[u]), 0);
    chk({nm, " busy after"}, 32'(busy[u]), 0);
  endtask

  initial begin
    int          i_at, d_at, n_ack, n_st, ack_at, u, a;
    bit          pd, we;
    logic [15:0] w;
    bit          order [$];

    reset = 1'b1;
    for (int k = 0; k < NU; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk_idle(0, "reset u0");
    chk_idle(1, "reset u1");
    reset = 1'b0;

    tbl[0] = '{0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    tbl[1] = '{0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[2] = '{1, 1'b1, 1'b1, 16'h0004, 16'h1234, 16'h0000};
    tbl[3] = '{1, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234};
    tbl[4] = '{0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[5] = '{0, 1'b1, 1'b1, 16'h00FF, 16'h0001, 16'h0000};
    tbl[6] = '{0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0001};
    tbl[7] = '{1, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234};
    for (int k = 0; k < 8; k++)
      txn(tbl[k].u, tbl[k].port_d, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].exp_rd,
          $sformatf("vec%0d", k));

    // Reset lands while the read is in ACCESS: no ack may follow.
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0010;
    @(negedge clk);
    chk("midrst busy before", 32'(busy[0]), 1);
    chk("midrst oe before", 32'(mem_oe[0]), 1);
    reset = 1'b1;
    d_req[0] = 1'b0;
    @(negedge clk);
    chk_idle(0, "midrst u0");
    reset = 1'b0;
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ack[0]) n_ack++;
    end
    chk("midrst no ack", 32'(n_ack), 0);
    chk("midrst busy", 32'(busy[0]), 0);

    // Simultaneous requests: loser waits one IDLE cycle after the winner's ack.
    do_reset();
    @(negedge clk);
    i_req[0] = 1'b1; i_addr[0] = 16'h0010;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0020; d_wdata[0] = 16'h5A5A;
    i_at = 0; d_at = 0;
    for (int c = 1; c <= 20 && (i_at == 0 || d_at == 0); c++) begin
      @(negedge clk);
      if (i_ack[0]) begin i_at = c; i_req[0] = 1'b0; end
      if (d_ack[0]) begin d_at = c; d_req[0] = 1'b0; end
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("simul i_ack cycle", 32'(i_at), RR ? 3 : 2 + 1 + 3);
    chk("simul d_ack cycle", 32'(d_at), RR ? 3 + 1 + 2 : 2);
    chk("simul i_rdata", 32'(i_rdata[0]), 32'h0000BEEF);
    txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, "simul readback");

    // Continuous conflicting reads: record the grant order of six accesses.
    do_reset();
    @(negedge clk);
    i_req[0] = 1'b1; i_addr[0] = 16'h0010;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h00FF;
    for (int c = 1; c <= 40 && order.size() < 6; c++) begin
      @(negedge clk);
      if (i_ack[0]) order.push_back(1'b0);
      if (d_ack[0]) order.push_back(1'b1);
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("contend count", 32'(order.size()), 6);
    for (int k = 0; k < 6 && k < order.size(); k++)
      chk($sformatf("contend grant%0d is_d", k), 32'(order[k]), RR ? 32'(k % 2) : 1);
    repeat (2) @(negedge clk);

    // Requester drops the write after one cycle and scrambles its inputs.
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0030; d_wdata[0] = 16'h7777;
    n_st = 0; n_ack = 0; ack_at = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_st[0]) begin
        n_st++;
        chk("drop st addr", 32'(mem_addr[0]), 32'h0030);
        chk("drop st data", 32'(mem_wdata[0]), 32'h7777);
      end
      if (d_ack[0]) begin n_ack++; ack_at = c; end
      if (c == 1) begin
        d_req[0] = 1'b0; d_addr[0] = 16'hFFFF; d_wdata[0] = 16'h0000;
      end
    end
    chk("drop st pulses", 32'(n_st), 1);
    chk("drop ack pulses", 32'(n_ack), 1);
    chk("drop ack cycle", 32'(ack_at), 2);
    txn(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h7777, "drop readback");

    // Random traffic against a shadow memory per instance.
    for (int uu = 0; uu < NU; uu++) begin
      for (int aa = 0; aa < 16; aa++) begin
        w = 16'($urandom);
        shadow[uu][aa] = w;
        txn(uu, 1'b1, 1'b1, 16'(aa), w, 16'h0000, $sformatf("init u%0d a%0d", uu, aa));
      end
    end
    for (int k = 0; k < 40; k++) begin
      u  = int'($urandom_range(0, 1));
      pd = 1'($urandom_range(0, 1));
      we = pd ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = int'($urandom_range(0, 15));
      w  = 16'($urandom);
      txn(u, pd, we, 16'(a), w, shadow[u][a], $sformatf("rnd%0d", k));
      if (we) shadow[u][a] = w;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
